vlc_ac_run_level_sched: RTL

//  Sequences one block of quantized AC coefficients (scan order) into run/level codeword requests for the
//  exp-Golomb coder instance that sits beside it, selecting the adaptive k per codeword. It tags the coder's
//  2-cycle-late sum/length results for the bit packer downstream and marks the end of each block.

---
 rtl/vlc_ac_run_level_sched.sv | 196 +++++++++++++++++++
 1 files changed

// File: rtl/vlc_ac_run_level_sched.sv
// ============================================================================
// Module  : vlc_ac_run_level_sched
// Brief   : AC run/level sequencer feeding an exp-Golomb coder, with a tag
//           pipeline that aligns the coder's delayed results for the packer.
// Revision: 1.0
// ============================================================================
`default_nettype none

module vlc_ac_run_level_sched #(
    parameter int N_AC   = 63,
    parameter int CW_LAT = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [15:0] in_coef,
    input  logic        hold,
    output logic        cw_issue,
    output logic [31:0] cw_val,
    output logic [2:0]  cw_k,
    output logic [1:0]  cw_is_add_setbit,
    output logic        cw_is_ac_level,
    output logic        cw_is_ac_minus_n,
    input  logic [31:0] gc_sum,
    input  logic [31:0] gc_len,
    output logic        len_valid,
    output logic        len_is_level,
    output logic [31:0] out_sum,
    output logic [31:0] out_len,
    output logic        blk_end,
    output logic        busy
);

    localparam int              c_IW       = $clog2(N_AC);
    localparam logic [c_IW-1:0] c_IDX_LAST = c_IW'(N_AC - 1);
    localparam logic [c_IW-1:0] c_RUN_MAX  = c_IW'(N_AC - 1);
    localparam logic [c_IW-1:0] c_PRUN_RST = c_IW'(4);
    localparam logic [16:0]     c_PLVL_RST = 17'd1;

    typedef enum logic [1:0] {
        COUNT     = 2'd0,
        RUN_GAP   = 2'd1,
        LEVEL     = 2'd2,
        LEVEL_GAP = 2'd3
    } state_t;

    state_t          r_state;
    logic [c_IW-1:0] r_idx;
    logic [c_IW-1:0] r_run;
    logic [c_IW-1:0] r_prev_run;
    logic [16:0]     r_prev_lvl;
    logic [16:0]     r_mag;
    logic            r_sign;
    logic            r_last;
    logic [31:0]     r_cw_val;
    logic [2:0]      r_cw_k;
    logic            r_cw_lvl;
    logic            r_cw_minus;
    logic [2:0]      r_tag [CW_LAT];

    logic            w_accept;
    logic            w_nz;
    logic            w_idx_last;
    logic [16:0]     w_sx;
    logic [16:0]     w_mag;
    logic            w_issue_run;
    logic            w_issue_lvl;
    logic [31:0]     w_run_val;
    logic [31:0]     w_lvl_val;
    logic [2:0]      w_k_run;
    logic [2:0]      w_k_lvl;
    logic [2:0]      w_tag_in;
    logic            w_tag_any;

    function automatic logic [2:0] k_sel(input logic [16:0] p);
        if (p <= 17'd1)      return 3'd0;
        else if (p <= 17'd3) return 3'd1;
        else                 return 3'd2;
    endfunction

    assign in_ready    = (r_state == COUNT) && !hold;
    assign w_accept    = in_valid && in_ready;
    assign w_nz        = (in_coef != 16'd0);
    assign w_idx_last  = (r_idx == c_IDX_LAST);
    // Sign-extend before negating so -32768 yields a magnitude of 32768.
    assign w_sx        = {in_coef[15], in_coef};
    assign w_mag       = in_coef[15] ? (~w_sx + 17'd1) : w_sx;

    assign w_issue_run = w_accept && w_nz;
    assign w_issue_lvl = (r_state == LEVEL) && !hold;
    assign w_run_val   = {{(32 - c_IW){1'b0}}, r_run};
    assign w_lvl_val   = {15'd0, r_mag - 17'd1};
    assign w_k_run     = k_sel({{(17 - c_IW){1'b0}}, r_prev_run});
    assign w_k_lvl     = k_sel(r_prev_lvl);

    // Coder inputs are live on the issue cycle and otherwise hold their last value.
    assign cw_issue         = w_issue_run || w_issue_lvl;
    assign cw_val           = w_issue_run ? w_run_val : (w_issue_lvl ? w_lvl_val : r_cw_val);
    assign cw_k             = w_issue_run ? w_k_run   : (w_issue_lvl ? w_k_lvl   : r_cw_k);
    assign cw_is_ac_level   = w_issue_run ? 1'b0      : (w_issue_lvl ? 1'b1      : r_cw_lvl);
    assign cw_is_ac_minus_n = w_issue_lvl ? r_sign    : r_cw_minus;
    assign cw_is_add_setbit = 2'b00;

    // Tag layout {valid, is_level, last}; an end-only tag has valid clear.
    always_comb begin
        w_tag_in = 3'b000;
        if (w_issue_run)
            w_tag_in = 3'b100;
        else if (w_issue_lvl)
            w_tag_in = {2'b11, r_last};
        else if (w_accept && w_idx_last)
            w_tag_in = 3'b001;
    end

    always_comb begin
        w_tag_any = 1'b0;
        for (int i = 0; i < CW_LAT; i++)
            w_tag_any = w_tag_any | (|r_tag[i]);
    end

    assign len_valid    = r_tag[CW_LAT-1][2];
    assign len_is_level = r_tag[CW_LAT-1][1];
    assign blk_end      = r_tag[CW_LAT-1][0];
    assign out_sum      = len_valid ? gc_sum : 32'd0;
    assign out_len      = len_valid ? gc_len : 32'd0;
    assign busy         = (r_state != COUNT) || w_tag_any;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state    <= COUNT;
            r_idx      <= '0;
            r_run      <= '0;
            r_prev_run <= c_PRUN_RST;
            r_prev_lvl <= c_PLVL_RST;
            r_mag      <= '0;
            r_sign     <= 1'b0;
            r_last     <= 1'b0;
            r_cw_val   <= '0;
            r_cw_k     <= '0;
            r_cw_lvl   <= 1'b0;
            r_cw_minus <= 1'b0;
            for (int i = 0; i < CW_LAT; i++)
                r_tag[i] <= 3'b000;
        end else begin
            r_cw_val   <= cw_val;
            r_cw_k     <= cw_k;
            r_cw_lvl   <= cw_is_ac_level;
            r_cw_minus <= cw_is_ac_minus_n;
            r_tag[0]   <= w_tag_in;
            for (int i = 1; i < CW_LAT; i++)
                r_tag[i] <= r_tag[i-1];

            case (r_state)
                COUNT: begin
                    if (w_accept) begin
                        r_idx <= w_idx_last ? '0 : r_idx + 1'b1;
                        if (w_nz) begin
                            r_mag   <= w_mag;
                            r_sign  <= in_coef[15];
                            r_last  <= w_idx_last;
                            r_state <= RUN_GAP;
                        end else if (w_idx_last) begin
                            r_run      <= '0;
                            r_prev_run <= c_PRUN_RST;
                            r_prev_lvl <= c_PLVL_RST;
                        end else if (r_run != c_RUN_MAX) begin
                            r_run <= r_run + 1'b1;
                        end
                    end
                end
                RUN_GAP: r_state <= LEVEL;
                LEVEL: begin
                    if (!hold) begin
                        r_run <= '0;
                        // Context restarts once the block's final level has been issued.
                        if (r_last) begin
                            r_prev_run <= c_PRUN_RST;
                            r_prev_lvl <= c_PLVL_RST;
                        end else begin
                            r_prev_run <= r_run;
                            r_prev_lvl <= r_mag;
                        end
                        r_last  <= 1'b0;
                        r_state <= LEVEL_GAP;
                    end
                end
                LEVEL_GAP: r_state <= COUNT;
                default:   r_state <= COUNT;
            endcase
        end
    end

endmodule

`default_nettype wire
